conv_window_gen: RTL
====================

// Module: conv_window_gen
// PURPOSE
//  Producer side of the 3x3 conv adder tree. Takes a raster-order pixel stream,
//  buffers two image lines, and emits a packed 3x3 window per valid position.
//  The bus layout matches the adder tree's num*in_width input.
//  Sits between the pixel source and the add tree in the conv datapath.
// PARAMETERS
//  IN_WIDTH  4   bits per pixel; signed two's complement, passed through unmodified
//  IMG_W     8   pixels per line; must be >= 3
//  IMG_H     8   lines per frame; must be >= 3
// PORTS
//  clk           in   1             single clock, all logic on posedge
//  rst           in   1             synchronous, active-high reset
//  in_valid      in   1             pixel strobe; no backpressure, every strobe is accepted
//  in_sof        in   1             qualified by in_valid: this pixel is (row 0, col 0)
//  in_pixel      in   IN_WIDTH      pixel value
//  win_valid     out  1             window bus holds a new 3x3 window this cycle
//  win_data      out  9*IN_WIDTH    packed window; element i at [(i+1)*IN_WIDTH-1 : i*IN_WIDTH]
//  frame_done    out  1             one-cycle pulse with the last window of a frame
// BEHAVIOUR
//  - Element map: i = 3*r + c. r=0 is the oldest (top) line, r=2 is the current line.
//    c=0 is the leftmost (oldest) column. Element 8 is the pixel just accepted.
//  - Counters: col in 0..IMG_W-1, row in 0..IMG_H-1. They advance only on in_valid.
//    col wraps to 0 and increments row. At (IMG_H-1, IMG_W-1) both wrap to 0.
//  - in_valid & in_sof: the pixel is treated as col=0, row=0, overriding the counters.
//    Next expected position is (0,1). Line-buffer contents are not cleared.
//  - Line buffers: two IMG_W-deep delay lines. They shift only on in_valid.
//    Row 1 of the window comes from the 1-line delay; row 0 comes from the 2-line delay.
//  - Window regs: 3 columns x 3 rows. They shift on in_valid; the new column is
//    {2-line-delayed, 1-line-delayed, in_pixel}.
//  - Output rule: accepting a pixel with row>=2 and col>=2 produces a registered window.
//    win_valid=1 and win_data are set on the NEXT posedge (latency 1 cycle).
//  - Windows never straddle a line or frame boundary, because col<2 or row<2 gates win_valid.
//  - win_data holds its value while win_valid=0; no idle-time change is required.
//  - frame_done=1 in the same cycle as the win_valid produced by pixel (IMG_H-1, IMG_W-1).
//  - in_valid gaps (bubbles) do not alter window contents or the output sequence.
//  - Reset values: win_valid=0, frame_done=0, win_data=0, col=0, row=0, window regs=0.
//    Line-buffer storage is not reset; the row gating guarantees stale data is never emitted.
//  - Reset mid-frame: outputs drop to reset values on the next edge. The next accepted
//    pixel is (0,0) whether or not in_sof is set.
//  - No arithmetic is performed. Widths are pure pass-through.
// STRUCTURE
//  - conv_pkg: localparam KSIZE=3, KNUM=KSIZE*KSIZE. Also the element-index helper
//    function idx(r,c)=3*r+c, shared with the add tree.
//  - Sub-module conv_line_buf: parameterised by width and depth, with enable-gated
//    shift register/RAM. Instantiated twice, chained.
//  - The top level holds the counters, the 3x3 window regs and the output regs.
// TESTING (IN_WIDTH=4, IMG_W=4, IMG_H=4; pixel value = 4*row+col)
//  1. One frame, in_valid continuous, in_sof on the first pixel.
//     -> exactly 4 win_valid, one cycle after pixels 10, 11, 14, 15.
//     -> first window elements 0..8 = {0,1,2,4,5,6,8,9,10}.
//  2. Same frame as test 1.
//     -> last window = {5,6,7,9,10,11,13,14,15}.
//     -> frame_done high only with that window.
//  3. Test 1 stimulus with in_valid low every other cycle.
//     -> identical 4 windows in identical order; each win_valid still 1 cycle after its pixel.
//  4. Assert rst after pixel 9, then send a fresh frame without in_sof.
//     -> no win_valid until new pixel 10.
//     -> windows match test 1 exactly.
//  5. in_sof on what would be pixel 6 of frame 1, then a full frame.
//     -> no win_valid before the new frame's pixel 10.
//     -> output matches test 1.
//  6. Two frames back-to-back, no gap. Frame 2 value = 15 - value.
//     -> 8 windows total, 2 frame_done pulses.
//     -> frame 2 first window = {15,14,13,11,10,9,7,6,5}.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and element-index helper for the 3x3 conv datapath.
package conv_pkg;

  localparam int unsigned KSIZE = 3;
  localparam int unsigned KNUM  = KSIZE * KSIZE;

  // Packed window element index: r=0 is the oldest line, c=0 the oldest column.
  function automatic int unsigned idx(input int unsigned r, input int unsigned c);
    return KSIZE * r + c;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// Enable-gated fixed-length delay line; dout is the sample written DEPTH enables ago.
module conv_line_buf #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d = {mem_q[DEPTH-2:0], din};
    end
  end

  // Storage is deliberately not reset; consumers gate out stale lines.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to packed 3x3 window generator feeding the conv adder tree.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 4,
  parameter int unsigned IMG_W    = 8,
  parameter int unsigned IMG_H    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [IN_WIDTH-1:0]      in_pixel,
  output logic                     win_valid,
  output logic [KNUM*IN_WIDTH-1:0] win_data,
  output logic                     frame_done
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic [KNUM-1:0][IN_WIDTH-1:0] win_q, win_d;
  logic [KNUM-1:0][IN_WIDTH-1:0] win_data_q, win_data_d;
  logic win_valid_q, win_valid_d;
  logic frame_done_q, frame_done_d;
  logic [IN_WIDTH-1:0] lb1_dout, lb2_dout;

  conv_line_buf #(.WIDTH(IN_WIDTH), .DEPTH(IMG_W)) u_lb1 (
    .clk  (clk),
    .en   (in_valid),
    .din  (in_pixel),
    .dout (lb1_dout)
  );

  conv_line_buf #(.WIDTH(IN_WIDTH), .DEPTH(IMG_W)) u_lb2 (
    .clk  (clk),
    .en   (in_valid),
    .din  (lb1_dout),
    .dout (lb2_dout)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_data_d   = win_data_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    cur_col      = in_sof ? '0 : col_q;
    cur_row      = in_sof ? '0 : row_q;

    if (in_valid) begin
      // Shift columns left; the incoming column lands at c=2.
      for (int unsigned r = 0; r < KSIZE; r++) begin
        win_d[idx(r, 0)] = win_q[idx(r, 1)];
        win_d[idx(r, 1)] = win_q[idx(r, 2)];
      end
      win_d[idx(0, 2)] = lb2_dout;
      win_d[idx(1, 2)] = lb1_dout;
      win_d[idx(2, 2)] = in_pixel;

      if (cur_col == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end

      if ((cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2))) begin
        win_valid_d  = 1'b1;
        win_data_d   = win_d;
        frame_done_d = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_data_q   <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_data_q   <= win_data_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign frame_done = frame_done_q;

endmodule
